ysyx_25020047_lsu: RTL and testbench

- Multi-cycle load/store unit directly downstream of the execute stage.
- Consumes the computed address/result plus read/write strobes, runs one transaction on a simple valid/ready memory bus, and hands load data, pass-through result or error to writeback.
- Lane steering (byte/word) and the response-timeout watchdog live here, so downstream stages see only 32-bit writeback data.

---
 rtl/ysyx_25020047_lsu_if.sv | 45 ++++
 rtl/ysyx_25020047_lsu.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_25020047_lsu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_lsu_if.sv
// LSU port bundle: execute-side handshake, memory request/response bus and
// writeback handshake. The master modport is the LSU's view; the slave modport
// is the surrounding pipeline/memory view.
interface ysyx_25020047_lsu_if;
    // execute -> LSU
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_read;
    logic        ex_write;
    logic        ex_size;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    // LSU -> memory
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    // LSU -> writeback
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic        wb_err;

    modport master (
        input  ex_valid, ex_read, ex_write, ex_size, ex_addr, ex_wdata,
        output ex_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output wb_valid, wb_data, wb_err,
        input  wb_ready
    );

    modport slave (
        output ex_valid, ex_read, ex_write, ex_size, ex_addr, ex_wdata,
        input  ex_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  wb_valid, wb_data, wb_err,
        output wb_ready
    );
endinterface

// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit: one op in flight, byte/word lane steering,
// response watchdog. Optional macro YSYX_25020047_LSU_MISALIGN_TRAP_EN turns
// misaligned word accesses into errors instead of silently aligning them.
module ysyx_25020047_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_25020047_lsu_if.master         bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;

    // op attributes still needed once the request has left
    logic        op_read, op_read_n;
    logic        op_size, op_size_n;
    logic [1:0]  op_lane, op_lane_n;

    logic        req_valid, req_valid_n;
    logic        req_we, req_we_n;
    logic [31:0] req_addr, req_addr_n;
    logic [31:0] req_wdata, req_wdata_n;
    logic [3:0]  req_wmask, req_wmask_n;

    logic        wb_valid, wb_valid_n;
    logic        wb_err, wb_err_n;
    logic [31:0] wb_data, wb_data_n;

    logic        misalign;
    logic [7:0]  resp_byte;

`ifdef YSYX_25020047_LSU_MISALIGN_TRAP_EN
    assign misalign = bus.ex_size && (bus.ex_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign bus.ex_ready       = (state == IDLE) && !rst;
    assign bus.mem_req_valid  = req_valid;
    assign bus.mem_req_we     = req_we;
    assign bus.mem_req_addr   = req_addr;
    assign bus.mem_req_wdata  = req_wdata;
    assign bus.mem_req_wmask  = req_wmask;
    assign bus.wb_valid       = wb_valid;
    assign bus.wb_data        = wb_data;
    assign bus.wb_err         = wb_err;

    // pick the addressed byte out of the returned word
    always_comb begin
        resp_byte = bus.mem_resp_rdata[7:0];
        case (op_lane)
            2'd0: resp_byte = bus.mem_resp_rdata[7:0];
            2'd1: resp_byte = bus.mem_resp_rdata[15:8];
            2'd2: resp_byte = bus.mem_resp_rdata[23:16];
            2'd3: resp_byte = bus.mem_resp_rdata[31:24];
            default: resp_byte = bus.mem_resp_rdata[7:0];
        endcase
    end

    // next-state and next-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        op_read_n   = op_read;
        op_size_n   = op_size;
        op_lane_n   = op_lane;
        req_valid_n = req_valid;
        req_we_n    = req_we;
        req_addr_n  = req_addr;
        req_wdata_n = req_wdata;
        req_wmask_n = req_wmask;
        wb_valid_n  = wb_valid;
        wb_err_n    = wb_err;
        wb_data_n   = wb_data;
        case (state)
            IDLE: begin
                if (bus.ex_valid) begin
                    op_read_n = bus.ex_read;
                    op_size_n = bus.ex_size;
                    op_lane_n = bus.ex_addr[1:0];
                    if (!bus.ex_read && !bus.ex_write) begin
                        // non-memory op: result flows straight through
                        state_n    = DONE;
                        wb_valid_n = 1'b1;
                        wb_err_n   = 1'b0;
                        wb_data_n  = bus.ex_addr;
                    end else if ((bus.ex_read && bus.ex_write) || misalign) begin
                        state_n    = DONE;
                        wb_valid_n = 1'b1;
                        wb_err_n   = 1'b1;
                        wb_data_n  = 32'h0;
                    end else begin
                        state_n     = REQ;
                        req_valid_n = 1'b1;
                        req_we_n    = bus.ex_write;
                        req_addr_n  = {bus.ex_addr[31:2], 2'b00};
                        if (!bus.ex_write) begin
                            req_wdata_n = 32'h0;
                            req_wmask_n = 4'b0000;
                        end else if (bus.ex_size) begin
                            req_wdata_n = bus.ex_wdata;
                            req_wmask_n = 4'b1111;
                        end else begin
                            req_wdata_n = {4{bus.ex_wdata[7:0]}};
                            req_wmask_n = 4'b0001 << bus.ex_addr[1:0];
                        end
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_n     = WAIT;
                    cnt_n       = 16'h0;
                    req_valid_n = 1'b0;
                    req_we_n    = 1'b0;
                    req_addr_n  = 32'h0;
                    req_wdata_n = 32'h0;
                    req_wmask_n = 4'b0000;
                end
            end
            WAIT: begin
                // a response on the timeout cycle takes priority over the error
                if (bus.mem_resp_valid) begin
                    state_n    = DONE;
                    wb_valid_n = 1'b1;
                    wb_err_n   = 1'b0;
                    if (!op_read)     wb_data_n = 32'h0;
                    else if (op_size) wb_data_n = bus.mem_resp_rdata;
                    else              wb_data_n = {24'h0, resp_byte};
                end else if (cnt == CNT_LAST) begin
                    state_n    = DONE;
                    wb_valid_n = 1'b1;
                    wb_err_n   = 1'b1;
                    wb_data_n  = 32'h0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DONE: begin
                if (bus.wb_ready) begin
                    state_n    = IDLE;
                    wb_valid_n = 1'b0;
                    wb_err_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'h0;
            op_read   <= 1'b0;
            op_size   <= 1'b0;
            op_lane   <= 2'b00;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            req_wmask <= 4'b0000;
            wb_valid  <= 1'b0;
            wb_err    <= 1'b0;
            wb_data   <= 32'h0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_read   <= op_read_n;
            op_size   <= op_size_n;
            op_lane   <= op_lane_n;
            req_valid <= req_valid_n;
            req_we    <= req_we_n;
            req_addr  <= req_addr_n;
            req_wdata <= req_wdata_n;
            req_wmask <= req_wmask_n;
            wb_valid  <= wb_valid_n;
            wb_err    <= wb_err_n;
            wb_data   <= wb_data_n;
        end
    end
endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for the LSU: stimulus pushes expected bus requests and
// writeback results; a memory responder and a writeback monitor check them.
module tb_ysyx_25020047_lsu;
    localparam int TO = 4;
`ifdef YSYX_25020047_LSU_MISALIGN_TRAP_EN
    localparam bit MIS_TRAP = 1'b1;
`else
    localparam bit MIS_TRAP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          rdy_dly;
        int          dly;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25020047_lsu_if bus ();

    ysyx_25020047_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    req_t reqq[$];
    wb_t  wbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hold_cnt = 0;
    int   hs_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // memory responder: checks each request against the scoreboard, then answers
    initial begin
        req_t e;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_req_valid) begin
                if (reqq.size() == 0) begin
                    fail_evt("unexpected_req");
                    bus.mem_req_ready = 1'b1;
                    @(negedge clk);
                    bus.mem_req_ready = 1'b0;
                end else begin
                    e = reqq.pop_front();
                    chk("req_addr", bus.mem_req_addr, e.addr);
                    chk("req_we", 32'(bus.mem_req_we), 32'(e.we));
                    chk("req_wmask", 32'(bus.mem_req_wmask), 32'(e.wmask));
                    if (e.we) chk("req_wdata", bus.mem_req_wdata, e.wdata);
                    for (int i = 0; i < e.rdy_dly; i++) begin
                        @(negedge clk);
                        chk("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
                        chk("req_hold_addr", bus.mem_req_addr, e.addr);
                    end
                    bus.mem_req_ready = 1'b1;
                    hs_count++;
                    @(negedge clk);
                    bus.mem_req_ready = 1'b0;
                    for (int i = 1; i < e.dly; i++) @(negedge clk);
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = e.rdata;
                    @(negedge clk);
                    bus.mem_resp_valid = 1'b0;
                    bus.mem_resp_rdata = $urandom;
                end
            end
        end
    end

    // writeback monitor: random backpressure, stability while stalled, scoreboard pop
    initial begin
        wb_t         e;
        bit          pending = 0;
        bit          rdy;
        logic [31:0] pdata = 32'h0;
        logic        perr = 1'b0;
        bus.wb_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0;
                bus.wb_ready = 1'b0;
            end else if (bus.wb_valid) begin
                if (pending) begin
                    chk("wb_hold_data", bus.wb_data, pdata);
                    chk("wb_hold_err", 32'(bus.wb_err), 32'(perr));
                end
                chk("ex_ready_busy", 32'(bus.ex_ready), 32'd0);
                if (hold_cnt > 0) begin
                    rdy = 0;
                    hold_cnt--;
                end else begin
                    rdy = ($urandom_range(0, 2) != 0);
                end
                bus.wb_ready = rdy;
                if (rdy) begin
                    pending = 0;
                    if (wbq.size() == 0) fail_evt("unexpected_wb");
                    else begin
                        e = wbq.pop_front();
                        chk("wb_data", bus.wb_data, e.data);
                        chk("wb_err", 32'(bus.wb_err), 32'(e.err));
                    end
                end else begin
                    pending = 1;
                    pdata   = bus.wb_data;
                    perr    = bus.wb_err;
                end
            end else begin
                pending = 0;
                bus.wb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // issue one op; called at a negedge, returns at a negedge
    task automatic issue(input bit rd, input bit wr, input bit sz,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rdy_dly, input int dly,
                         input bit drop = 0);
        req_t r;
        wb_t  w;
        bit   has_req;
        int   t = 0;
        has_req = (rd != wr) && !(MIS_TRAP && sz && (addr % 4 != 0));
        if (!rd && !wr)        w = '{addr, 1'b0};
        else if (!has_req)     w = '{32'h0, 1'b1};
        else if (dly > TO)     w = '{32'h0, 1'b1};
        else if (wr)           w = '{32'h0, 1'b0};
        else if (sz)           w = '{rdata, 1'b0};
        else                   w = '{(rdata >> (8 * (addr % 4))) & 32'hFF, 1'b0};
        r.we      = wr;
        r.addr    = addr & 32'hFFFF_FFFC;
        r.wdata   = sz ? wdata : (wdata & 32'hFF) * 32'h0101_0101;
        r.wmask   = !wr ? 4'h0 : (sz ? 4'hF : 4'(1 << (addr % 4)));
        r.rdata   = rdata;
        r.rdy_dly = rdy_dly;
        r.dly     = dly;
        while (!bus.ex_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ex_ready) begin
            fail_evt("ex_ready_timeout");
            return;
        end
        if (has_req) reqq.push_back(r);
        if (!drop) wbq.push_back(w);
        bus.ex_valid = 1'b1;
        bus.ex_read  = rd;
        bus.ex_write = wr;
        bus.ex_size  = sz;
        bus.ex_addr  = addr;
        bus.ex_wdata = wdata;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.ex_addr  = $urandom;
        if (has_req) chk("req_valid_after_accept", 32'(bus.mem_req_valid), 32'd1);
        else begin
            chk("wb_latency", 32'(bus.wb_valid), 32'd1);
            chk("no_req", 32'(bus.mem_req_valid), 32'd0);
        end
    endtask

    // main stimulus
    initial begin
        int h;
        int t;
        bus.ex_valid = 1'b0;
        bus.ex_read  = 1'b0;
        bus.ex_write = 1'b0;
        bus.ex_size  = 1'b0;
        bus.ex_addr  = 32'h0;
        bus.ex_wdata = 32'h0;
        @(negedge clk);
        chk("rst_ex_ready", 32'(bus.ex_ready), 32'd0);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_wb_err", 32'(bus.wb_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ex_ready", 32'(bus.ex_ready), 32'd1);

        // directed cases
        issue(0, 0, 1, 32'h0000_1234, 32'h0, 32'h0, 0, 1);               // pass-through
        issue(1, 0, 0, 32'h8000_0003, 32'h0, 32'hAABB_CCDD, 3, 2);       // lbu
        issue(0, 1, 0, 32'h8000_0002, 32'h1234_5678, 32'h0, 0, 1);       // sb
        issue(1, 0, 1, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1, TO + 1);  // lw timeout
        issue(1, 0, 1, 32'h8000_0014, 32'h0, 32'h0BAD_BEEF, 0, TO);      // resp on timeout cycle
        issue(1, 1, 1, 32'h8000_0020, 32'h0, 32'h0, 0, 1);               // illegal strobes
        issue(1, 0, 1, 32'h8000_0001, 32'h0, 32'h1122_3344, 0, 2);       // misaligned lw
        issue(0, 1, 1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 2, 3);       // sw
        hold_cnt = 5;
        issue(0, 0, 0, 32'h0000_0ABC, 32'h0, 32'h0, 0, 1);               // backpressure

        // reset during WAIT: op dropped, late response ignored
        h = hs_count;
        issue(1, 0, 1, 32'h8000_0030, 32'h0, 32'h5555_AAAA, 0, 3, 1);
        t = 0;
        while (hs_count == h && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (hs_count == h) fail_evt("rst_test_handshake_timeout");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ex_ready", 32'(bus.ex_ready), 32'd0);
        chk("midrst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("midrst_wb_data", bus.wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        end

        // randomized ops
        for (int i = 0; i < 80; i++) begin
            int          op;
            bit          sz;
            logic [31:0] a;
            op = $urandom_range(0, 7);
            sz = 1'($urandom_range(0, 1));
            a  = $urandom;
            if (sz && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(op == 0 || op == 7, op >= 4 ? 1'b1 : 1'b0, sz, a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(1, TO + 2));
        end

        t = 0;
        while ((wbq.size() != 0 || reqq.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (wbq.size() != 0) fail_evt("wb_drain_timeout");
        if (reqq.size() != 0) fail_evt("req_drain_timeout");
        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
